// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back sequencer.
//   wb_kind_e  : instruction kinds offered to write-back (values 5..7 are illegal)
//   wb_state_e : sequencer FSM states
//   SEL_*      : {sel2,sel1,sel0} codes for the write-back mux
package wb_pkg;

  typedef enum logic [2:0] {
    KIND_ALU  = 3'd0,
    KIND_LOAD = 3'd1,
    KIND_MFHI = 3'd2,
    KIND_MFLO = 3'd3,
    KIND_JAL  = 3'd4
  } wb_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WAIT_HL  = 2'd2,
    ST_WRITE    = 2'd3
  } wb_state_e;

  localparam logic [2:0] SEL_ALU  = 3'b000;
  localparam logic [2:0] SEL_LOAD = 3'b001;
  localparam logic [2:0] SEL_HI   = 3'b010;
  localparam logic [2:0] SEL_LO   = 3'b011;
  localparam logic [2:0] SEL_PC   = 3'b100;

  function automatic logic kind_is_legal(input logic [2:0] kind);
    return (kind <= KIND_JAL);
  endfunction

  function automatic logic [2:0] sel_for_kind(input logic [2:0] kind);
    logic [2:0] sel;
    case (kind)
      KIND_LOAD: sel = SEL_LOAD;
      KIND_MFHI: sel = SEL_HI;
      KIND_MFLO: sel = SEL_LO;
      KIND_JAL:  sel = SEL_PC;
      default:   sel = SEL_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// wb_wait_timer: up-counter bounding how long a load may wait for memory.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count one more waiting cycle
//   expired    : this enabled cycle is the MEM_WAIT_MAX-th waiting cycle
module wb_wait_timer #(
  parameter int TMR_W        = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == TMR_W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: write-back stage controller for the register-file write mux.
// Accepts one retiring instruction at a time, waits for its source (load data
// or idle mult/div) and issues a single register-file write with mux selects.
//   wb_valid/wb_ready/wb_kind/wb_rd : instruction handshake from execute
//   mem_rvalid, muldiv_busy         : source readiness
//   flush                           : synchronous abort of in-flight work
//   sel0/sel1/sel2                  : write-back mux selects (held until next capture)
//   reg_write/reg_waddr             : register-file write port control
//   stall                           : upstream hold while waiting on a source
//   mem_timeout, illegal_kind       : one-cycle error pulses
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int TMR_W        = 4,
  parameter int RA_REG       = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [2:0] wb_kind,
  input  logic [4:0] wb_rd,
  input  logic       mem_rvalid,
  input  logic       muldiv_busy,
  input  logic       flush,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       reg_write,
  output logic [4:0] reg_waddr,
  output logic       stall,
  output logic       mem_timeout,
  output logic       illegal_kind
);

  wb_state_e  state_q, state_d, accept_target;
  logic       accept;
  logic       tmr_clr, tmr_en, tmr_expired;
  logic [2:0] sel_q;
  logic [4:0] rd_q;
  logic       illegal_q, timeout_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Where a freshly accepted instruction goes next
  always_comb begin
    accept_target = ST_IDLE;
    case (wb_kind)
      KIND_ALU, KIND_JAL:   accept_target = ST_WRITE;
      KIND_LOAD:            accept_target = ST_WAIT_MEM;
      KIND_MFHI, KIND_MFLO: accept_target = muldiv_busy ? ST_WAIT_HL : ST_WRITE;
      default:              accept_target = ST_IDLE;
    endcase
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (accept) state_d = accept_target;
        ST_WAIT_MEM: begin
          if (mem_rvalid)       state_d = ST_WRITE;
          else if (tmr_expired) state_d = ST_IDLE;
        end
        ST_WAIT_HL:  if (!muldiv_busy) state_d = ST_WRITE;
        ST_WRITE:    state_d = accept ? accept_target : ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    wb_ready  = ((state_q == ST_IDLE) || (state_q == ST_WRITE)) && !flush;
    stall     = (state_q == ST_WAIT_MEM) || (state_q == ST_WAIT_HL);
    reg_write = (state_q == ST_WRITE) && (rd_q != 5'd0) && !flush;
  end

  assign accept = wb_valid && wb_ready;

  // Counter runs only while waiting on memory; any other state holds it at
  // zero, so each entry to WAIT_MEM starts from a clean count.
  assign tmr_clr = (state_q != ST_WAIT_MEM) || flush;
  assign tmr_en  = (state_q == ST_WAIT_MEM) && !mem_rvalid && !flush;

  wb_wait_timer #(
    .TMR_W        (TMR_W),
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Capture of destination and selects; an illegal kind is dropped without
  // disturbing what the mux currently points at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_ALU;
      rd_q  <= 5'd0;
    end else if (accept && kind_is_legal(wb_kind)) begin
      sel_q <= sel_for_kind(wb_kind);
      rd_q  <= (wb_kind == KIND_JAL) ? 5'(RA_REG) : wb_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= accept && !kind_is_legal(wb_kind);
      timeout_q <= tmr_expired;
    end
  end

  assign sel0         = sel_q[0];
  assign sel1         = sel_q[1];
  assign sel2         = sel_q[2];
  assign reg_waddr    = rd_q;
  assign mem_timeout  = timeout_q;
  assign illegal_kind = illegal_q;

endmodule
